risc_v_mike_fetch: RTL and testbench
====================================

RISC_V_MIKE_FETCH -- requirements
Module: risc_v_mike_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-005 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-006 SHALL have port imem_req_addr  output  DATA_32_W  word-aligned fetch address.
REQ-007 SHALL have port imem_rsp_valid  input  1  response valid; in order, latency >=1 cycle, no backpressure.
REQ-008 SHALL have port imem_rsp_data  input  INSTR_32_W  fetched instruction word.
REQ-009 SHALL have port instruction  output  INSTR_32_W  instruction to risc_v_mike_ctrl.
REQ-010 SHALL have port instr_pc  output  DATA_32_W  PC of instruction.
REQ-011 SHALL have port instr_valid  output  1  instruction/instr_pc valid.
REQ-012 SHALL have port instr_ready  input  1  downstream accepts instruction.
REQ-013 SHALL have port pc_src  input  1  redirect request (taken branch/jump).
REQ-014 SHALL have port pc_target  input  DATA_32_W  redirect address.

Function
REQ-015 SHALL hold fetch PC; request handshake = imem_req_valid & imem_req_ready; each handshake advances PC by 4, wrapping 32'hFFFF_FFFC -> 0.
REQ-016 SHALL buffer responses in a 2-entry in-order FIFO, each entry holding {instruction, pc}.
REQ-017 SHALL assert imem_req_valid only in FETCH when (outstanding + FIFO occupancy) < 2, so FIFO never overflows.
REQ-018 SHALL drive instruction/instr_pc from FIFO head, instr_valid = FIFO non-empty; pop on instr_valid & instr_ready.
REQ-019 SHALL hold imem_req_addr and instruction/instr_pc stable while the corresponding valid is high and not accepted.
REQ-020 SHALL allow response-to-instr_valid latency of 1 cycle (FIFO registered); empty-FIFO bypass is not permitted.
REQ-021 SHALL implement FSM: RST -> FETCH (first cycle after rst_n release); FETCH -> FLUSH on pc_src with outstanding>0; FETCH -> FETCH on pc_src with outstanding=0; FLUSH -> FETCH when drop count reaches 0.
REQ-022 On pc_src: SHALL clear FIFO, load PC <= {pc_target[31:2],2'b00}, set drop count = outstanding minus responses arriving that cycle, suppress imem_req_valid that cycle.
REQ-023 In FLUSH: SHALL discard each response and decrement drop count; no requests issued; further pc_src reloads PC only.
REQ-024 pc_src coincident with instr handshake: SHALL complete the handshake, then flush.
REQ-025 pc_src coincident with imem request handshake: that request SHALL count as outstanding and be dropped.
REQ-026 Response while drop count=0 SHALL never be discarded.

Reset
REQ-027 rst_n low SHALL asynchronously set: PC=RESET_PC, FIFO empty, outstanding=0, drop=0, state=RST, imem_req_valid=0, instr_valid=0, instruction=0, instr_pc=0, imem_req_addr=RESET_PC.
REQ-028 Reset mid-transaction SHALL abandon outstanding requests; memory is reset in the same domain.

Configuration
REQ-029 With RISC_V_MIKE_FETCH_PERF_EN defined: SHALL add outputs perf_fetch_cnt and perf_flush_cnt (DATA_32_W, wrapping), counting instr handshakes and pc_src events, reset to 0.
REQ-030 Without RISC_V_MIKE_FETCH_PERF_EN: SHALL omit those ports and counters; all other behaviour identical.

Structure
REQ-031 FSM state enum t_fetch_state (RST, FETCH, FLUSH) and FIFO entry struct t_fetch_entry SHALL live in risc_v_mike_pkg alongside INSTR_32_W/DATA_32_W.
REQ-032 FIFO SHALL be sub-module risc_v_mike_fetch_fifo (depth 2); FSM/PC/counters in risc_v_mike_fetch.

Verification
REQ-033 Reset release, RESET_PC=0, ready=1, latency 1, instr_ready=1 -> addresses 0,4,8,... and instr_pc sequence 0,4,8 with matching data.
REQ-034 instr_ready=0 for 10 cycles -> exactly 2 requests issued, instr_valid held, data stable; release -> in-order delivery, no loss.
REQ-035 pc_src with pc_target=32'h100 and 2 outstanding -> 2 responses dropped, next delivered instr_pc=32'h100.
REQ-036 pc_target=32'h103 -> next fetch address 32'h100; PC at 32'hFFFF_FFFC -> next address 0.
REQ-037 rst_n asserted during FLUSH -> outputs immediately at reset values; fetch restarts at RESET_PC.
REQ-038 With RISC_V_MIKE_FETCH_PERF_EN: 5 delivered, 2 redirects -> perf_fetch_cnt=5, perf_flush_cnt=2.

Source files
------------

// File: rtl/risc_v_mike_pkg.sv
// Shared widths, FSM state and FIFO entry type for the risc_v_mike fetch slice.
// Imported by the fetch interface, the response FIFO and the fetch top.
package risc_v_mike_pkg;
   localparam int INSTR_32_W = 32;
   localparam int DATA_32_W  = 32;

   typedef enum logic [1:0] {
      RST   = 2'd0,
      FETCH = 2'd1,
      FLUSH = 2'd2
   } t_fetch_state;

   typedef struct packed {
      logic [INSTR_32_W-1:0] instr;
      logic [DATA_32_W-1:0]  pc;
   } t_fetch_entry;
endpackage

// File: rtl/risc_v_mike_fetch_if.sv
// Fetch-side bundle: instruction-memory request/response plus the decoded-instruction handshake.
// master = fetch unit, slave = memory/downstream environment.
interface risc_v_mike_fetch_if;
   import risc_v_mike_pkg::*;

   logic                  imem_req_valid;
   logic                  imem_req_ready;
   logic [DATA_32_W-1:0]  imem_req_addr;
   logic                  imem_rsp_valid;
   logic [INSTR_32_W-1:0] imem_rsp_data;
   logic [INSTR_32_W-1:0] instruction;
   logic [DATA_32_W-1:0]  instr_pc;
   logic                  instr_valid;
   logic                  instr_ready;
   logic                  pc_src;
   logic [DATA_32_W-1:0]  pc_target;

   modport master (
      output imem_req_valid, imem_req_addr, instruction, instr_pc, instr_valid,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, pc_src, pc_target
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, instruction, instr_pc, instr_valid,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, pc_src, pc_target
   );
endinterface

// File: rtl/risc_v_mike_fetch_fifo.sv
// Two-entry in-order buffer of {instruction, pc}; registered, so a push is visible next cycle.
// No full check: the fetch top never has more than two words in flight or buffered.
module risc_v_mike_fetch_fifo
   import risc_v_mike_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_push,
   input  t_fetch_entry i_push_dat,
   input  logic         i_pop,
   input  logic         i_clr,
   output t_fetch_entry o_head,
   output logic         o_vld,
   output logic [1:0]   o_cnt
);
   t_fetch_entry r_mem [2];
   logic         r_rd_ptr;
   logic         r_wr_ptr;
   logic [1:0]   r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_cnt    <= 2'd0;
      end else if (i_clr) begin
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_cnt    <= 2'd0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (i_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, i_pop};
      end
   end

   assign o_head = r_mem[r_rd_ptr];
   assign o_vld  = (r_cnt != 2'd0);
   assign o_cnt  = r_cnt;
endmodule

// File: rtl/risc_v_mike_fetch.sv
// Fetch unit: PC, request issue, redirect/flush FSM; response reaches instr_valid one cycle later.
// At most two words in flight+buffered; optional perf counters via RISC_V_MIKE_FETCH_PERF_EN.
module risc_v_mike_fetch
   import risc_v_mike_pkg::*;
#(
   parameter logic [DATA_32_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   risc_v_mike_fetch_if.master  bus
`ifdef RISC_V_MIKE_FETCH_PERF_EN
   ,
   output logic [DATA_32_W-1:0] perf_fetch_cnt,
   output logic [DATA_32_W-1:0] perf_flush_cnt
`endif
);
   t_fetch_state         r_state;
   t_fetch_state         w_state_nxt;
   logic [DATA_32_W-1:0] r_pc;
   logic [1:0]           r_outstanding;
   logic [1:0]           r_drop;
   logic [1:0]           w_fifo_cnt;
   logic                 w_fifo_vld;
   logic                 w_req_hs;
   logic                 w_rsp;
   logic                 w_pop;
   logic                 w_redirect;
   logic                 w_push;
   logic                 w_can_req;
   logic [DATA_32_W-1:0] w_target;
   logic [DATA_32_W-1:0] w_rsp_pc;
   t_fetch_entry         w_push_dat;
   t_fetch_entry         w_head;

   assign w_req_hs   = bus.imem_req_valid & bus.imem_req_ready;
   assign w_rsp      = bus.imem_rsp_valid & (r_outstanding != 2'd0);
   assign w_pop      = w_fifo_vld & bus.instr_ready;
   assign w_redirect = bus.pc_src & (r_state != RST);
   assign w_target   = bus.pc_target & 32'hFFFF_FFFC;
   assign w_can_req  = ({1'b0, r_outstanding} + {1'b0, w_fifo_cnt}) < 3'd2;
   // Requests since the last redirect are sequential, so the oldest one sits outstanding*4 behind PC.
   assign w_rsp_pc   = r_pc - {{(DATA_32_W-4){1'b0}}, r_outstanding, 2'b00};
   assign w_push     = w_rsp & (r_state == FETCH) & ~bus.pc_src;
   assign w_push_dat = '{instr: bus.imem_rsp_data, pc: w_rsp_pc};

   risc_v_mike_fetch_fifo u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_push     (w_push),
      .i_push_dat (w_push_dat),
      .i_pop      (w_pop),
      .i_clr      (w_redirect),
      .o_head     (w_head),
      .o_vld      (w_fifo_vld),
      .o_cnt      (w_fifo_cnt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= RST;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         RST:     w_state_nxt = FETCH;
         FETCH:   if (bus.pc_src && r_outstanding != 2'd0) w_state_nxt = FLUSH;
         FLUSH:   if (r_drop == 2'd0 || (r_drop == 2'd1 && w_rsp)) w_state_nxt = FETCH;
         default: w_state_nxt = RST;
      endcase
   end

   always_comb begin
      bus.imem_req_valid = (r_state == FETCH) & ~bus.pc_src & w_can_req;
   end

   assign bus.imem_req_addr = r_pc;
   assign bus.instr_valid   = w_fifo_vld;
   assign bus.instruction   = w_head.instr;
   assign bus.instr_pc      = w_head.pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc          <= RESET_PC;
         r_outstanding <= 2'd0;
         r_drop        <= 2'd0;
      end else begin
         r_outstanding <= r_outstanding + {1'b0, w_req_hs} - {1'b0, w_rsp};
         if (w_redirect)    r_pc <= w_target;
         else if (w_req_hs) r_pc <= r_pc + 32'd4;
         // A response landing on the redirect cycle is discarded with the cleared FIFO.
         if (w_redirect && r_state == FETCH)
            r_drop <= r_outstanding - {1'b0, w_rsp};
         else if (r_state == FLUSH && w_rsp && r_drop != 2'd0)
            r_drop <= r_drop - 2'd1;
      end
   end

`ifdef RISC_V_MIKE_FETCH_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetch_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (w_pop)      perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         if (w_redirect) perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_risc_v_mike_fetch.sv
// Scoreboard bench for risc_v_mike_fetch: behavioural memory, expected-address and expected-delivery queues.
// Perf counter checks are compiled in when RISC_V_MIKE_FETCH_PERF_EN is defined.
module tb_risc_v_mike_fetch;
   import risc_v_mike_pkg::*;

   typedef struct { int due; logic [31:0] a; } pend_t;
   typedef struct { logic [31:0] pc; logic [31:0] ins; } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc   = 0;
   int   lat   = 1;
   int   req_cnt = 0;
   pend_t       pend[$];
   logic [31:0] exp_addr[$];
   exp_t        exp_data[$];
   exp_t        mon_e;

   risc_v_mike_fetch_if bus ();

`ifdef RISC_V_MIKE_FETCH_PERF_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_flush_cnt;
`endif

   risc_v_mike_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef RISC_V_MIKE_FETCH_PERF_EN
      , .perf_fetch_cnt (perf_fetch_cnt)
      , .perf_flush_cnt (perf_flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return {~a[15:0], a[31:16]} ^ 32'h5A5A_3C3C;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_addr(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) exp_addr.push_back(base + 32'(4 * i));
   endtask

   task automatic push_dat(input logic [31:0] base, input int n);
      logic [31:0] a;
      for (int i = 0; i < n; i++) begin
         a = base + 32'(4 * i);
         exp_data.push_back('{a, mem_data(a)});
      end
   endtask

   // Memory: in-order, fixed latency per phase, reset together with the DUT.
   initial begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (!rst_n) pend.delete();
         if (rst_n && pend.size() != 0 && pend[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_data(pend[0].a);
            void'(pend.pop_front());
         end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
         end
      end
   end

   // Monitor: sample handshakes mid-cycle, before the edge that completes them.
   always @(negedge clk) begin
      if (!rst_n) begin
         req_cnt = 0;
      end else begin
         if (bus.imem_req_valid && bus.imem_req_ready) begin
            req_cnt++;
            pend.push_back('{cyc + lat, bus.imem_req_addr});
            if (exp_addr.size() != 0) chk("imem_req_addr", bus.imem_req_addr, exp_addr.pop_front());
         end
         if (bus.instr_valid && bus.instr_ready) begin
            if (exp_data.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL unexpected_delivery: got pc %h, expected none", bus.instr_pc);
            end else begin
               mon_e = exp_data.pop_front();
               chk("instr_pc", bus.instr_pc, mon_e.pc);
               chk("instruction", bus.instruction, mon_e.ins);
            end
         end
      end
   end

   task automatic do_reset();
      rst_n      = 1'b0;
      bus.pc_src = 1'b0;
      exp_addr.delete();
      exp_data.delete();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic wait_addr_left(input int n);
      int t = 0;
      while (exp_addr.size() > n && t < 200) begin
         @(posedge clk); #1; t++;
      end
      if (exp_addr.size() > n) begin
         n_chk++; n_err++;
         $display("FAIL req_timeout: got %0d pending requests, expected %0d", exp_addr.size(), n);
      end
   endtask

   task automatic finish_phase();
      int t = 0;
      wait_addr_left(0);
      bus.imem_req_ready = 1'b0;
      while (exp_data.size() != 0 && t < 200) begin
         @(posedge clk); #1; t++;
      end
      repeat (8) @(posedge clk);
      #1;
      chk("deliveries_left", exp_data.size(), 0);
   endtask

   task automatic redirect_phase(input logic [31:0] t1, input logic [31:0] t2, input int npulse,
                                 input logic [31:0] base, input int n);
      do_reset();
      lat = 1;
      bus.imem_req_ready = 1'b1;
      bus.instr_ready    = 1'b1;
      push_addr(base, n);
      push_dat(base, n);
      @(posedge clk); #1;
      bus.pc_target = t1;
      bus.pc_src    = 1'b1;
      @(posedge clk); #1;
      if (npulse == 2) begin
         bus.pc_target = t2;
         @(posedge clk); #1;
      end
      bus.pc_src = 1'b0;
      finish_phase();
   endtask

   initial begin
      bus.imem_req_ready = 1'b0;
      bus.instr_ready    = 1'b0;
      bus.pc_src         = 1'b0;
      bus.pc_target      = '0;
      #12;
      chk("rst_req_valid", bus.imem_req_valid, 0);
      chk("rst_instr_valid", bus.instr_valid, 0);
      chk("rst_instruction", bus.instruction, 0);
      chk("rst_instr_pc", bus.instr_pc, 0);
      chk("rst_req_addr", bus.imem_req_addr, 32'h0);

      // Streaming fetch from RESET_PC.
      do_reset();
      lat = 1;
      bus.imem_req_ready = 1'b1;
      bus.instr_ready    = 1'b1;
      push_addr(32'h0, 8);
      push_dat(32'h0, 8);
      finish_phase();

      // Downstream stall: two words fill the path, head held stable.
      do_reset();
      lat = 1;
      bus.imem_req_ready = 1'b1;
      bus.instr_ready    = 1'b0;
      push_addr(32'h0, 4);
      push_dat(32'h0, 4);
      repeat (10) begin
         @(posedge clk); #1;
         if (bus.instr_valid) begin
            chk("stall_instr_pc", bus.instr_pc, 32'h0);
            chk("stall_instruction", bus.instruction, mem_data(32'h0));
         end
      end
      chk("stall_req_cnt", req_cnt, 2);
      chk("stall_instr_valid", bus.instr_valid, 1);
      bus.instr_ready = 1'b1;
      finish_phase();

      // Redirect with two outstanding: both stale responses dropped.
      do_reset();
      lat = 3;
      bus.imem_req_ready = 1'b1;
      bus.instr_ready    = 1'b1;
      push_addr(32'h0, 2);
      push_addr(32'h100, 2);
      push_dat(32'h100, 2);
      wait_addr_left(2);
      bus.pc_target = 32'h100;
      bus.pc_src    = 1'b1;
      @(posedge clk); #1;
      bus.pc_src = 1'b0;
      chk("flush_req_valid", bus.imem_req_valid, 0);
      chk("flush_instr_valid", bus.instr_valid, 0);
      finish_phase();

      // Unaligned target and PC wrap.
      redirect_phase(32'h103, 32'h103, 1, 32'h100, 2);
      redirect_phase(32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 3);

      // Asynchronous reset while flushing.
      do_reset();
      lat = 3;
      bus.imem_req_ready = 1'b1;
      bus.instr_ready    = 1'b1;
      push_addr(32'h0, 2);
      wait_addr_left(0);
      bus.pc_target = 32'h200;
      bus.pc_src    = 1'b1;
      @(posedge clk); #1;
      bus.pc_src = 1'b0;
      chk("flush2_req_addr", bus.imem_req_addr, 32'h200);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_req_valid", bus.imem_req_valid, 0);
      chk("arst_instr_valid", bus.instr_valid, 0);
      chk("arst_instruction", bus.instruction, 0);
      chk("arst_instr_pc", bus.instr_pc, 0);
      chk("arst_req_addr", bus.imem_req_addr, 32'h0);
      do_reset();
      lat = 1;
      bus.imem_req_ready = 1'b1;
      push_addr(32'h0, 3);
      push_dat(32'h0, 3);
      finish_phase();

      // Back-to-back redirects, last target wins; five deliveries.
      redirect_phase(32'h40, 32'h8B, 2, 32'h88, 5);
`ifdef RISC_V_MIKE_FETCH_PERF_EN
      chk("perf_fetch_cnt", perf_fetch_cnt, 32'd5);
      chk("perf_flush_cnt", perf_flush_cnt, 32'd2);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, expected finish before 500000");
      $fatal(1);
   end
endmodule
